norm_lzc_pipe: RTL and testbench
================================

Name: norm_lzc_pipe

Overview:
Parametrised, pipelined leading-zero normaliser for the FP datapath. It is the successor to the fixed 27-bit leading-one encoder. Each accepted word gets:
- leading-zero count from the MSB,
- left-shift normalisation,
- exponent adjustment, with optional clamping for subnormal results.

Valid/ready handshake on both sides with full backpressure. It sits between the mantissa add/sub stage and the rounding stage.

Parameters:
WIDTH, 27, mantissa/data width in bits (>=2).
EXP_W, 8, exponent width in bits.
MAX_SHIFT, 27, upper limit on applied shift (1..WIDTH).
CLAMP_TO_EXP, 1, 1 = applied shift also limited to in_exp (subnormal result); 0 = not limited.
CW, $clog2(WIDTH+1), derived width of the count field; not to be overridden.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
in_data  in  WIDTH  unnormalised mantissa
in_exp  in  EXP_W  unsigned biased exponent
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  normalised mantissa
out_exp  out  EXP_W  adjusted exponent
out_count  out  CW  shift actually applied
out_zero  out  1  in_data was all zeros
out_sat  out  1  shift was limited below true leading-zero count

Behaviour:
- One clock domain; reset is synchronous and active-high. rst high at a clock edge clears all state:
  - s1_valid = s2_valid = 0;
  - out_data = 0, out_exp = 0, out_count = 0, out_zero = 0, out_sat = 0.
  - in_ready is combinational; it reads 1 in the cycle after reset.
- Reset mid-operation discards any in-flight words; nothing is emitted for them.
- Transfer occurs on an edge where valid && ready.
- Stage 1 registers, on input transfer:
  - lz = number of zeros above the highest set bit of in_data, range 0..WIDTH; WIDTH when in_data == 0.
  - in_data, in_exp.
  - zero = (in_data == 0).
  - shift = min(lz, MAX_SHIFT), further min'd with in_exp when CLAMP_TO_EXP = 1.
  - sat = (shift < lz).
- Stage 2 registers:
  - out_data = s1_data << shift, logical, zero-filled, truncated to WIDTH.
  - out_exp = s1_exp − shift, modulo 2^EXP_W. No wrap can occur when CLAMP_TO_EXP = 1; wrap is the caller's concern when it is 0.
  - out_count = shift; out_zero = zero; out_sat = sat.
- Zero input: out_data = 0, out_zero = 1. out_count = min(WIDTH, MAX_SHIFT[, in_exp]). out_sat = 1 whenever that count < WIDTH.
- Latency: exactly 2 cycles from input transfer to out_valid when unstalled. Throughput is one word per cycle.
- Stall rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
- While out_valid && !out_ready:
  - all out_* outputs are held stable;
  - s1 is held;
  - in_ready falls once s1 is full.
- Simultaneous output transfer and input transfer in the same cycle: both complete, with no bubble and no loss.
- Ordering is strictly FIFO. No word may be dropped or duplicated.
- Between results (out_valid = 0), out_* hold their last values.

Test Plan:
1. WIDTH = 27, in_data = 27'h0200000 (bit 21 set), in_exp = 100, out_ready = 1 → two cycles later: out_count = 5, out_data = 27'h4000000, out_exp = 95, out_zero = 0, out_sat = 0.
2. in_data = 0, in_exp = 200 → out_data = 0, out_zero = 1, out_count = 27, out_exp = 173, out_sat = 0. Same input with in_exp = 3, CLAMP_TO_EXP = 1 → out_count = 3, out_exp = 0, out_sat = 1.
3. Subnormal clamp: in_data = 27'h0000001, in_exp = 10, CLAMP_TO_EXP = 1 → out_count = 10, out_data = 27'h0000400, out_exp = 0, out_sat = 1. With CLAMP_TO_EXP = 0 → out_count = 26, out_exp = 240 (wrapped), out_sat = 0.
4. Backpressure: stream 5 words back-to-back, hold out_ready = 0 for 4 cycles → in_ready drops after 2 accepted words, outputs stay stable. After release, all 5 results emerge in order, one per cycle.
5. Reset mid-stream: assert rst for 1 cycle with both stages full → next cycle out_valid = 0, in_ready = 1, and no stale word ever appears.
6. Randomised sweep, including MAX_SHIFT = 8, WIDTH = 24 → every result matches the reference model (lz/clamp/shift/exp); latency = 2 when unstalled.

Source files
------------

// File: rtl/norm_lzc_pipe.sv
// Two-stage leading-zero normaliser: counts leading zeros, left-shifts the mantissa to put the
// leading one at the MSB, and lowers the exponent by the applied shift. The shift can be capped
// by MAX_SHIFT and, optionally, by the incoming exponent so that results become subnormal
// instead of wrapping. Valid/ready on both sides with full backpressure.
module norm_lzc_pipe #(
  parameter int unsigned WIDTH        = 27,
  parameter int unsigned EXP_W        = 8,
  parameter int unsigned MAX_SHIFT    = 27,
  parameter bit          CLAMP_TO_EXP = 1'b1,
  parameter int unsigned CW           = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [EXP_W-1:0] out_exp,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic             out_sat
);

  // Common width for comparing the count against MAX_SHIFT and the exponent.
  localparam int unsigned    CmpW      = (CW > EXP_W) ? CW : EXP_W;
  localparam logic [CmpW-1:0] MaxShiftC = CmpW'(MAX_SHIFT);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [EXP_W-1:0] s1_exp;
  logic [CW-1:0]    s1_shift;
  logic             s1_zero;
  logic             s1_sat;
  logic             s2_valid;

  logic [CW-1:0]    lz;
  logic [CmpW-1:0]  lz_ext;
  logic [CmpW-1:0]  lim;
  logic [CW-1:0]    shift_d;
  logic             sat_d;
  logic             advance;

  // Stage 2 can take a new word when empty or when its current word is leaving.
  assign advance   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || advance;
  assign out_valid = s2_valid;

  // Leading-zero count: the highest set bit wins, WIDTH when the word is zero.
  always_comb begin
    lz = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_data[i]) lz = CW'(WIDTH - 1 - i);
    end
  end

  // Applied shift: limited by MAX_SHIFT and optionally by the exponent (subnormal result).
  always_comb begin
    lz_ext = CmpW'(lz);
    lim    = (lz_ext < MaxShiftC) ? lz_ext : MaxShiftC;
    if (CLAMP_TO_EXP && (CmpW'(in_exp) < lim)) lim = CmpW'(in_exp);
    // lim never exceeds lz <= WIDTH, so it always fits in CW bits.
    shift_d = CW'(lim);
    sat_d   = (lim < lz_ext);
  end

  // Stage 1: capture the word and its count; refills whenever it empties or moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
      s1_shift <= '0;
      s1_zero  <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_exp   <= in_exp;
        s1_shift <= shift_d;
        s1_zero  <= (in_data == '0);
        s1_sat   <= sat_d;
      end
    end
  end

  // Stage 2: shift and adjust the exponent; outputs hold while stalled or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_exp   <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= s1_data << s1_shift;
        // Modulo 2^EXP_W; cannot wrap when the shift is clamped to the exponent.
        out_exp   <= s1_exp - EXP_W'(s1_shift);
        out_count <= s1_shift;
        out_zero  <= s1_zero;
        out_sat   <= s1_sat;
      end
    end
  end

endmodule

// File: tb/tb_norm_lzc_pipe.sv
// Scoreboard bench for norm_lzc_pipe. Three instances share one handshake stream:
// 27-bit clamped, 27-bit unclamped, 24-bit with MAX_SHIFT = 8 (clamped).
module tb_norm_lzc_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  ex;
    logic [7:0]  cnt;
    logic        zero;
    logic        sat;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [26:0] in_data;
  logic [7:0]  in_exp;

  logic        in_ready_a, out_valid_a, out_zero_a, out_sat_a;
  logic [26:0] out_data_a;
  logic [7:0]  out_exp_a;
  logic [4:0]  out_count_a;

  logic        in_ready_b, out_valid_b, out_zero_b, out_sat_b;
  logic [26:0] out_data_b;
  logic [7:0]  out_exp_b;
  logic [4:0]  out_count_b;

  logic        in_ready_c, out_valid_c, out_zero_c, out_sat_c;
  logic [23:0] out_data_c;
  logic [7:0]  out_exp_c;
  logic [4:0]  out_count_c;

  norm_lzc_pipe #(.WIDTH(27), .EXP_W(8), .MAX_SHIFT(27), .CLAMP_TO_EXP(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_exp(in_exp), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_exp(out_exp_a), .out_count(out_count_a), .out_zero(out_zero_a), .out_sat(out_sat_a)
  );

  norm_lzc_pipe #(.WIDTH(27), .EXP_W(8), .MAX_SHIFT(27), .CLAMP_TO_EXP(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_exp(in_exp), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_exp(out_exp_b), .out_count(out_count_b), .out_zero(out_zero_b), .out_sat(out_sat_b)
  );

  norm_lzc_pipe #(.WIDTH(24), .EXP_W(8), .MAX_SHIFT(8), .CLAMP_TO_EXP(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data[23:0]),
    .in_exp(in_exp), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .out_exp(out_exp_c), .out_count(out_count_c), .out_zero(out_zero_c), .out_sat(out_sat_c)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  bit   rand_ready = 0;
  int   cfg_w[3]  = '{27, 27, 24};
  int   cfg_ms[3] = '{27, 27, 8};
  bit   cfg_cl[3] = '{1'b1, 1'b0, 1'b1};
  res_t q[3][$];
  res_t got[3];
  res_t prev[3];
  bit   stalled[3];
  logic ov[3];
  logic ir[3];
  res_t want_r;

  logic [26:0] dir_d[4];
  logic [7:0]  dir_e[4];
  res_t        dir_x[4][3];
  logic [26:0] bp_d[5];
  logic [7:0]  bp_e[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk(input logic [31:0] d, input logic [7:0] e, input logic [7:0] c,
                              input logic z, input logic s);
    res_t r;
    r.data = d; r.ex = e; r.cnt = c; r.zero = z; r.sat = s;
    return r;
  endfunction

  // Reference normaliser for one configuration.
  function automatic res_t model(input logic [31:0] d_in, input logic [7:0] e, input int w,
                                 input int ms, input bit cl);
    res_t        r;
    logic [63:0] mask;
    logic [31:0] d;
    int          lz;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    d    = d_in & mask[31:0];
    lz   = w;
    for (int i = 0; i < w; i++) if (d[i]) lz = w - 1 - i;
    sh = (lz < ms) ? lz : ms;
    if (cl && (int'(e) < sh)) sh = int'(e);
    r.data = 32'((64'(d) << sh) & mask);
    r.ex   = e - 8'(sh);
    r.cnt  = 8'(sh);
    r.zero = (d == 32'd0);
    r.sat  = (sh < lz);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] want_v);
    n_checks++;
    if (got_v !== want_v) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got_v, want_v);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t g, input res_t w);
    chk({tag, "_data"},  64'(g.data), 64'(w.data));
    chk({tag, "_exp"},   64'(g.ex),   64'(w.ex));
    chk({tag, "_count"}, 64'(g.cnt),  64'(w.cnt));
    chk({tag, "_zero"},  64'(g.zero), 64'(w.zero));
    chk({tag, "_sat"},   64'(g.sat),  64'(w.sat));
  endtask

  always_comb begin
    got[0] = mk(32'(out_data_a), out_exp_a, 8'(out_count_a), out_zero_a, out_sat_a);
    got[1] = mk(32'(out_data_b), out_exp_b, 8'(out_count_b), out_zero_b, out_sat_b);
    got[2] = mk(32'(out_data_c), out_exp_c, 8'(out_count_c), out_zero_c, out_sat_c);
    ov[0] = out_valid_a; ov[1] = out_valid_b; ov[2] = out_valid_c;
    ir[0] = in_ready_a;  ir[1] = in_ready_b;  ir[2] = in_ready_c;
  end

  // Monitor: pop/compare on output transfers, push model results on input transfers,
  // and require outputs to hold across stalled cycles.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        q[i].delete();
        stalled[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stalled[i]) chk($sformatf("hold%0d", i), 64'(got[i]), 64'(prev[i]));
        stalled[i] = ov[i] && !out_ready;
        prev[i]    = got[i];
        if (ov[i] && out_ready) begin
          if (i == 0) n_out++;
          if (q[i].size() == 0) begin
            chk($sformatf("spurious%0d", i), 64'd1, 64'd0);
          end else begin
            want_r = q[i].pop_front();
            cmp_res($sformatf("dut%0d", i), got[i], want_r);
          end
        end
        if (in_valid && ir[i])
          q[i].push_back(model({5'd0, in_data}, in_exp, cfg_w[i], cfg_ms[i], cfg_cl[i]));
      end
    end
  end

  // Random downstream backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Offer one word until accepted (bounded); returns at 1 ns after the accepting edge.
  task automatic send(input logic [26:0] d, input logic [7:0] e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_exp   = e;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready_a;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (q[0].size() + q[1].size() + q[2].size()) != 0; t++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 64'(q[i].size()), 64'd0);
  endtask

  initial begin
    int   k;
    int   n0;
    bit   acc;
    logic [31:0] r;
    logic [7:0]  e;

    dir_d[0] = 27'h0200000; dir_e[0] = 8'd100;
    dir_x[0][0] = mk(32'h4000000, 8'd95, 8'd5, 1'b0, 1'b0);
    dir_x[0][1] = mk(32'h4000000, 8'd95, 8'd5, 1'b0, 1'b0);
    dir_x[0][2] = mk(32'h0800000, 8'd98, 8'd2, 1'b0, 1'b0);
    dir_d[1] = 27'h0; dir_e[1] = 8'd200;
    dir_x[1][0] = mk(32'h0, 8'd173, 8'd27, 1'b1, 1'b0);
    dir_x[1][1] = mk(32'h0, 8'd173, 8'd27, 1'b1, 1'b0);
    dir_x[1][2] = mk(32'h0, 8'd192, 8'd8, 1'b1, 1'b1);
    dir_d[2] = 27'h0; dir_e[2] = 8'd3;
    dir_x[2][0] = mk(32'h0, 8'd0, 8'd3, 1'b1, 1'b1);
    dir_x[2][1] = mk(32'h0, 8'd232, 8'd27, 1'b1, 1'b0);
    dir_x[2][2] = mk(32'h0, 8'd0, 8'd3, 1'b1, 1'b1);
    dir_d[3] = 27'h0000001; dir_e[3] = 8'd10;
    dir_x[3][0] = mk(32'h0000400, 8'd0, 8'd10, 1'b0, 1'b1);
    dir_x[3][1] = mk(32'h4000000, 8'd240, 8'd26, 1'b0, 1'b0);
    dir_x[3][2] = mk(32'h0000100, 8'd2, 8'd8, 1'b0, 1'b1);

    bp_d[0] = 27'h0000001; bp_e[0] = 8'd50;
    bp_d[1] = 27'h7ffffff; bp_e[1] = 8'd60;
    bp_d[2] = 27'h0001234; bp_e[2] = 8'd5;
    bp_d[3] = 27'h0000000; bp_e[3] = 8'd20;
    bp_d[4] = 27'h0400000; bp_e[4] = 8'd130;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_exp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready",  64'(in_ready_a),  64'd1);
    cmp_res("rst", got[0], mk(32'h0, 8'h0, 8'h0, 1'b0, 1'b0));

    // Directed cases with two-cycle latency on an empty pipe.
    for (int n = 0; n < 4; n++) begin
      send(dir_d[n], dir_e[n]);
      chk("lat_early", 64'(out_valid_a), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_valid", 64'(out_valid_a), 64'd1);
      for (int i = 0; i < 3; i++) cmp_res($sformatf("dir%0d_%0d", n, i), got[i], dir_x[n][i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Backpressure: only two words fit while the output is stalled.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = bp_d[k]; in_exp = bp_e[k];
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready_a), 64'd0);
    n0 = n_out;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 5; c++) begin
      in_valid = 1'b1; in_data = bp_d[k]; in_exp = bp_e[k];
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_back_to_back", 64'(n_out - n0), 64'd5);
    drain();

    // Reset with both stages full: nothing in flight may emerge.
    out_ready = 1'b0;
    send(27'h0000abc, 8'd40);
    send(27'h1000000, 8'd41);
    n0 = n_out;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready_a),  64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", 64'(n_out), 64'(n0));

    // Random sweep with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) r = 32'd0;
      e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
      send(r[26:0], e);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
